// File: rtl/mem_pkg.sv
// Shared types and constants for the SLC-3 SRAM access controller.
package mem_pkg;

  localparam int MEM_WAIT_W       = 4;
  localparam int MEM_WAIT_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    RELEASE
  } mem_state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable wait-state down-counter; load has priority, dec holds at zero.
module mem_wait_counter
  import mem_pkg::*;
#(
  parameter int W = MEM_WAIT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// SLC-3 SRAM sequencer: one access per request, WAIT_CYCLES+1 strobe cycles, then a one-cycle mem_ready.
// Defining MEM_PERF_CNT_EN adds rd_count/wr_count completion counters.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES = MEM_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic [15:0] sram_rdata,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_wdata,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [15:0] rdata,
  output logic        mem_ready
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  mem_state_t state, state_d;
  logic       op;
  logic       op_d;
  logic       accept;
  logic       finish;
  logic       load;
  logic       dec;
  logic       cnt_zero;
  logic       ce_n_d, oe_n_d, we_n_d;

  mem_wait_counter #(.W(MEM_WAIT_W)) u_wait (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .load_val (MEM_WAIT_W'(WAIT_CYCLES)),
    .dec      (dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    finish  = 1'b0;
    load    = 1'b0;
    dec     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          accept  = 1'b1;
          load    = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_zero) begin
          finish  = 1'b1;
          state_d = DONE;
        end else begin
          dec = 1'b1;
        end
      end
      DONE:    state_d = mem_req ? RELEASE : IDLE;
      RELEASE: if (!mem_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are registered from the next state so they never glitch on a state decode.
    op_d   = accept ? mem_we : op;
    ce_n_d = (state_d != ACCESS);
    oe_n_d = !((state_d == ACCESS) && !op_d);
    we_n_d = !((state_d == ACCESS) && op_d);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      op         <= 1'b0;
      sram_addr  <= 16'h0000;
      sram_wdata <= 16'h0000;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      rdata      <= 16'h0000;
      mem_ready  <= 1'b0;
    end else begin
      state     <= state_d;
      op        <= op_d;
      sram_ce_n <= ce_n_d;
      sram_oe_n <= oe_n_d;
      sram_we_n <= we_n_d;
      mem_ready <= (state_d == DONE);
      if (accept) begin
        sram_addr  <= addr;
        sram_wdata <= wdata;
      end
      if (finish && !op) begin
        rdata <= sram_rdata;
      end
    end
  end

`ifdef MEM_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_count <= 16'h0000;
      wr_count <= 16'h0000;
    end else if (finish) begin
      if (op) wr_count <= wr_count + 16'd1;
      else    rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases then random accesses against a transaction model.
module tb_mem_access_ctrl;

`ifdef MEM_PERF_CNT_EN
  localparam int WAIT = 0;
`else
  localparam int WAIT = 2;
`endif

  logic        clk;
  logic        reset_n;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] sram_rdata;
  logic [15:0] sram_addr;
  logic [15:0] sram_wdata;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [15:0] rdata;
  logic        mem_ready;
`ifdef MEM_PERF_CNT_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] exp_rdata;
  logic [15:0] exp_rd;
  logic [15:0] exp_wr;

  mem_access_ctrl #(.WAIT_CYCLES(WAIT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .addr       (addr),
    .wdata      (wdata),
    .sram_rdata (sram_rdata),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .rdata      (rdata),
    .mem_ready  (mem_ready)
`ifdef MEM_PERF_CNT_EN
    ,
    .rd_count   (rd_count),
    .wr_count   (wr_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ce_n"}, {15'd0, sram_ce_n}, 16'd1);
    chk({tag, "_oe_n"}, {15'd0, sram_oe_n}, 16'd1);
    chk({tag, "_we_n"}, {15'd0, sram_we_n}, 16'd1);
    chk({tag, "_rdy"},  {15'd0, mem_ready}, 16'd0);
  endtask

  // One complete transaction: accept, WAIT+1 strobe cycles, ready pulse, optional hold, release.
  task automatic do_access(input logic we, input logic [15:0] a, input logic [15:0] d,
                           input logic [15:0] rv, input int hold);
    logic [15:0] exp_oe, exp_we;
    exp_oe = we ? 16'd1 : 16'd0;
    exp_we = we ? 16'd0 : 16'd1;
    mem_req = 1'b1;
    mem_we  = we;
    addr    = a;
    wdata   = d;
    chk("pre_ce_n", {15'd0, sram_ce_n}, 16'd1);
    tick();
    // Operands change right after acceptance; the access must not notice.
    addr   = 16'hFFFF;
    wdata  = 16'h0000;
    mem_we = ~we;
    for (int k = 0; k <= WAIT; k++) begin
      sram_rdata = (k == WAIT) ? rv : ~rv;
      chk("acc_ce_n",  {15'd0, sram_ce_n}, 16'd0);
      chk("acc_oe_n",  {15'd0, sram_oe_n}, exp_oe);
      chk("acc_we_n",  {15'd0, sram_we_n}, exp_we);
      chk("acc_addr",  sram_addr, a);
      chk("acc_wdata", sram_wdata, d);
      chk("acc_rdy",   {15'd0, mem_ready}, 16'd0);
      tick();
    end
    sram_rdata = 16'h0BAD;
    if (we) exp_wr = exp_wr + 16'd1;
    else begin
      exp_rdata = rv;
      exp_rd    = exp_rd + 16'd1;
    end
    chk("done_rdy",  {15'd0, mem_ready}, 16'd1);
    chk("done_ce_n", {15'd0, sram_ce_n}, 16'd1);
    chk("done_oe_n", {15'd0, sram_oe_n}, 16'd1);
    chk("done_we_n", {15'd0, sram_we_n}, 16'd1);
    chk("done_rdata", rdata, exp_rdata);
`ifdef MEM_PERF_CNT_EN
    chk("rd_count", rd_count, exp_rd);
    chk("wr_count", wr_count, exp_wr);
`endif
    mem_we = $urandom_range(1, 0) == 1;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk_quiet("hold");
      chk("hold_rdata", rdata, exp_rdata);
    end
    mem_req = 1'b0;
    tick();
    chk_quiet("idle");
  endtask

  initial begin
    reset_n    = 1'b0;
    mem_req    = 1'b1;
    mem_we     = 1'b0;
    addr       = 16'h1111;
    wdata      = 16'h2222;
    sram_rdata = 16'h0BAD;
    exp_rdata  = 16'h0000;
    exp_rd     = 16'h0000;
    exp_wr     = 16'h0000;

    // Reset with a request pending: reset wins and nothing is accepted.
    tick();
    tick();
    chk_quiet("rst");
    chk("rst_addr",  sram_addr,  16'h0000);
    chk("rst_wdata", sram_wdata, 16'h0000);
    chk("rst_rdata", rdata,      16'h0000);
`ifdef MEM_PERF_CNT_EN
    chk("rst_rd_count", rd_count, 16'h0000);
    chk("rst_wr_count", wr_count, 16'h0000);
`endif
    reset_n = 1'b1;
    mem_req = 1'b0;
    tick();
    chk_quiet("post_rst");

    do_access(1'b0, 16'h3000, 16'h5555, 16'hBEEF, 0);
    do_access(1'b1, 16'h3001, 16'h1234, 16'hC0DE, 0);
    chk("rdata_after_write", rdata, 16'hBEEF);
    do_access(1'b0, 16'h3002, 16'h0000, 16'hA5A5, 6);

    // Reset during the second ACCESS cycle abandons the read.
    mem_req    = 1'b1;
    mem_we     = 1'b0;
    addr       = 16'h3003;
    sram_rdata = 16'h7777;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    exp_rdata = 16'h0000;
    exp_rd    = 16'h0000;
    exp_wr    = 16'h0000;
    chk_quiet("midrst");
    chk("midrst_rdata", rdata, 16'h0000);
    chk("midrst_addr",  sram_addr, 16'h0000);
    tick();
    chk_quiet("midrst_hold");
    reset_n = 1'b1;
    mem_req = 1'b0;
    tick();
    chk_quiet("midrst_rel");
    do_access(1'b0, 16'h3004, 16'h0000, 16'h4321, 1);

`ifdef MEM_PERF_CNT_EN
    do_access(1'b0, 16'h0010, 16'h0000, 16'h0001, 0);
    do_access(1'b1, 16'h0011, 16'h0022, 16'h0002, 0);
    do_access(1'b0, 16'h0012, 16'h0000, 16'h0003, 0);
    do_access(1'b1, 16'h0013, 16'h0044, 16'h0004, 0);
    chk("perf_rd3", rd_count, 16'd3);
    chk("perf_wr2", wr_count, 16'd2);
    dut.rd_count = 16'hFFFF;
    exp_rd       = 16'hFFFF;
    do_access(1'b0, 16'h0014, 16'h0000, 16'h0005, 0);
    chk("perf_wrap", rd_count, 16'h0000);
`endif

    for (int i = 0; i < 40; i++) begin
      logic        r_we;
      logic [15:0] r_a, r_d, r_v;
      int          r_hold, r_gap;
      r_we   = $urandom_range(1, 0) == 1;
      r_a    = 16'($urandom);
      r_d    = 16'($urandom);
      r_v    = 16'($urandom);
      r_hold = $urandom_range(4, 0);
      r_gap  = $urandom_range(2, 0);
      do_access(r_we, r_a, r_d, r_v, r_hold);
      for (int g = 0; g < r_gap; g++) begin
        addr  = 16'($urandom);
        wdata = 16'($urandom);
        tick();
        chk_quiet("gap");
        chk("gap_rdata", rdata, exp_rdata);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences one SRAM read or write per request for the SLC-3 datapath.
- Sits between the control unit's MAR/MDR and the external 16-bit SRAM.
- The latched read data feeds the memory-data input of the MDR source selector, one stage upstream of the MDR register.
- Inserts a programmable number of wait states and returns a single-cycle ready pulse to the control unit.

Parameters:
- WAIT_CYCLES, 2, extra SRAM access cycles after the first; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  synchronous active-low reset.
- mem_req  input  1  access request from the control unit; held high until mem_ready is seen.
- mem_we  input  1  1 = write, 0 = read; sampled with mem_req.
- addr  input  16  address from MAR.
- wdata  input  16  write data from MDR.
- sram_rdata  input  16  data returned by the SRAM.
- sram_addr  output  16  SRAM address.
- sram_wdata  output  16  SRAM write data.
- sram_ce_n  output  1  chip enable, active low.
- sram_oe_n  output  1  output enable, active low.
- sram_we_n  output  1  write enable, active low.
- rdata  output  16  last completed read data, routed to the MDR selector.
- mem_ready  output  1  one-cycle completion pulse.

Behaviour:
- One clock, clk. Reset is synchronous and active-low on reset_n, sampled only on the rising edge of clk.
- Reset values:
  - state = IDLE.
  - sram_ce_n, sram_oe_n, sram_we_n = 1.
  - sram_addr, sram_wdata, rdata = 16'h0000.
  - mem_ready = 0.
  - wait counter = 0.
- States: IDLE, ACCESS, DONE, RELEASE.
- IDLE:
  - Strobes inactive.
  - On an edge with mem_req=1: latch addr to sram_addr, wdata to sram_wdata, and mem_we to an internal op flag.
  - Load counter with WAIT_CYCLES; go to ACCESS.
- ACCESS:
  - sram_ce_n=0.
  - Read: sram_oe_n=0, sram_we_n=1. Write: sram_we_n=0, sram_oe_n=1.
  - On each edge with counter≠0: decrement the counter.
  - On the edge with counter=0: for a read, capture sram_rdata into rdata; go to DONE.
  - ACCESS therefore lasts exactly WAIT_CYCLES+1 cycles.
- DONE:
  - Strobes inactive; mem_ready=1 for exactly this cycle.
  - Next state is IDLE if mem_req=0, else RELEASE.
- RELEASE:
  - Strobes inactive, mem_ready=0.
  - Go to IDLE on the first edge with mem_req=0.
  - A request that is still held high is never re-executed.
- Latency: with acceptance edge E0, mem_ready is high during the cycle after edge E0+WAIT_CYCLES+1.
  - WAIT_CYCLES=2 gives 4 cycles from acceptance to ready.
- Operands are frozen during the access: changes on addr, wdata or mem_we after acceptance have no effect on the access in flight.
- rdata holds its value until the next read completes; writes never modify rdata.
- Outputs are registered: sram_addr and sram_wdata are stable for the whole of ACCESS.
- Strobes are decoded from state and are glitch-free relative to clk.
- reset_n=0 mid-access: on that edge all strobes deassert and state returns to IDLE; the in-flight access is abandoned and mem_ready does not pulse.
- mem_req=1 together with reset_n=0: reset wins, and the request is not accepted that edge.

Optional Feature:
- MEM_PERF_CNT_EN, defined:
  - Adds outputs rd_count[15:0] and wr_count[15:0].
  - The counter matching the op increments by 1 on entry to DONE.
  - Wraps 16'hFFFF→16'h0000; both reset to 0.
- MEM_PERF_CNT_EN undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package mem_pkg holds:
  - enum mem_state_t {IDLE, ACCESS, DONE, RELEASE}.
  - localparam MEM_WAIT_W = 4.
  - Default-wait constant MEM_WAIT_DEFAULT = 2.
- Sub-module mem_wait_counter: loadable down-counter with load, dec and zero flag, width MEM_WAIT_W.

Test Plan:
- Read, WAIT_CYCLES=2, addr=16'h3000, sram_rdata=16'hBEEF: sram_oe_n low for 3 cycles; mem_ready high in the 4th cycle after acceptance; rdata=16'hBEEF; sram_we_n stays 1.
- Write addr=16'h3001, wdata=16'h1234: sram_we_n low for 3 cycles with sram_addr=16'h3001 and sram_wdata=16'h1234; rdata unchanged from the prior read (16'hBEEF).
- mem_req held high for 6 cycles after mem_ready: exactly one access and one mem_ready pulse; FSM stays in RELEASE until mem_req drops.
- During ACCESS, change addr to 16'hFFFF and wdata to 16'h0000: sram_addr and sram_wdata keep their latched values.
- reset_n=0 on the second ACCESS cycle: next cycle all strobes are 1, mem_ready=0, rdata=0; a new read afterward completes normally.
- WAIT_CYCLES=0 build, plus MEM_PERF_CNT_EN: ACCESS lasts 1 cycle. Then 3 reads and 2 writes give rd_count=3 and wr_count=2; preloading rd_count to 16'hFFFF and doing one read gives 16'h0000.
